// File: rtl/osc_seq_decoder_if.sv
// Sample/decode bus between the oscillator-state source and osc_seq_decoder.
interface osc_seq_decoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [1:0]       state_in;
  logic             a_valid;
  logic             a_out;
  logic             case_id;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] switch_count;

  // Source side: drives samples, observes decode results.
  modport master (
    output in_valid, state_in,
    input  a_valid, a_out, case_id, locked, err, err_count, switch_count
  );

  // Decoder side.
  modport slave (
    input  in_valid, state_in,
    output a_valid, a_out, case_id, locked, err, err_count, switch_count
  );
endinterface

// File: rtl/osc_seq_decoder.sv
// Recovers the control bit A from a 2-bit mode oscillator state stream,
// tracks lock and keeps saturating error / switch statistics.
module osc_seq_decoder #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  osc_seq_decoder_if.slave   bus
);

  // run only needs to count 0..LOCK_N-1; reaching LOCK_N-1 plus one more legal step locks
  localparam int unsigned RUN_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [1:0]       r_prev, w_prev_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt;
  logic             r_a_valid, w_a_valid_nxt;
  logic             r_a_out, w_a_out_nxt;
  logic             r_case_id, w_case_id_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic [CNT_W-1:0] r_switch_count, w_switch_count_nxt;

  logic w_legal_a0;
  logic w_legal_a1;
  logic w_legal;

  // Legal moves flip exactly one bit: LSB for A=0, MSB for A=1.
  assign w_legal_a0 = (bus.state_in == {r_prev[1], ~r_prev[0]});
  assign w_legal_a1 = (bus.state_in == {~r_prev[1], r_prev[0]});
  assign w_legal    = w_legal_a0 | w_legal_a1;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_EMPTY;
      r_prev         <= 2'b00;
      r_run          <= '0;
      r_a_valid      <= 1'b0;
      r_a_out        <= 1'b0;
      r_case_id      <= 1'b0;
      r_locked       <= 1'b0;
      r_err          <= 1'b0;
      r_err_count    <= '0;
      r_switch_count <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_prev         <= w_prev_nxt;
      r_run          <= w_run_nxt;
      r_a_valid      <= w_a_valid_nxt;
      r_a_out        <= w_a_out_nxt;
      r_case_id      <= w_case_id_nxt;
      r_locked       <= w_locked_nxt;
      r_err          <= w_err_nxt;
      r_err_count    <= w_err_count_nxt;
      r_switch_count <= w_switch_count_nxt;
    end
  end

  // Next-state and next-output decode for each accepted sample.
  always_comb begin
    w_state_nxt        = r_state;
    w_prev_nxt         = r_prev;
    w_run_nxt          = r_run;
    w_a_valid_nxt      = 1'b0;
    w_a_out_nxt        = r_a_out;
    w_case_id_nxt      = r_case_id;
    w_err_nxt          = 1'b0;
    w_err_count_nxt    = r_err_count;
    w_switch_count_nxt = r_switch_count;

    if (bus.in_valid) begin
      // Every accepted sample, legal or not, becomes the new reference.
      w_prev_nxt    = bus.state_in;
      w_case_id_nxt = bus.state_in[1];
    end

    case (r_state)
      S_EMPTY: begin
        if (bus.in_valid) begin
          w_state_nxt = S_TRACK;
          w_run_nxt   = '0;
        end
      end
      S_TRACK, S_LOCKED: begin
        if (bus.in_valid) begin
          if (w_legal) begin
            w_a_valid_nxt = 1'b1;
            w_a_out_nxt   = w_legal_a1;
            if (w_legal_a1 && (r_switch_count != CNT_MAX)) begin
              w_switch_count_nxt = r_switch_count + CNT_W'(1);
            end
            if (r_state == S_TRACK) begin
              if (r_run == RUN_LAST) begin
                w_state_nxt = S_LOCKED;
                w_run_nxt   = '0;
              end else begin
                w_run_nxt = r_run + RUN_W'(1);
              end
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_run_nxt   = '0;
            w_state_nxt = S_TRACK;
            if (r_err_count != CNT_MAX) begin
              w_err_count_nxt = r_err_count + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_run_nxt   = '0;
      end
    endcase

    w_locked_nxt = (w_state_nxt == S_LOCKED);
  end

  assign bus.a_valid      = r_a_valid;
  assign bus.a_out        = r_a_out;
  assign bus.case_id      = r_case_id;
  assign bus.locked       = r_locked;
  assign bus.err          = r_err;
  assign bus.err_count    = r_err_count;
  assign bus.switch_count = r_switch_count;

endmodule
